// File: rtl/split_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : split_stim_gen
//  Purpose  : Candidate-assignment generator for the split_* constraint
//             checker interface. It presents packed assignment vectors on
//             cand and samples the checker verdict chk_x after CHK_LAT
//             cycles. The search stops on the first satisfying assignment
//             or when the try budget runs out.
//  Ports    : clk, rst_n (async, active low)
//             start/seed/max_tries   - launch a search (sampled in IDLE only)
//             cand/cand_valid        - candidate presented to the checker
//             chk_x                  - checker verdict for cand
//             busy/done              - search in progress / one-cycle finish
//             found/sol/tries        - result of the last or current search
//  Options  : STIM_GEN_EXHAUSTIVE_EN - when defined, candidates enumerate
//             seed, seed+1, ... (zero seed allowed) instead of a Galois LFSR.
//  Revision : 1.0 - initial release
// ============================================================================
module split_stim_gen #(
    parameter int                VEC_W     = 32,
    parameter int                CNT_W     = 16,
    parameter int                CHK_LAT   = 0,
    parameter logic [VEC_W-1:0]  LFSR_TAPS = VEC_W'(32'h80200003)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VEC_W-1:0] seed,
    input  logic [CNT_W-1:0] max_tries,
    output logic [VEC_W-1:0] cand,
    output logic             cand_valid,
    input  logic             chk_x,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [VEC_W-1:0] sol,
    output logic [CNT_W-1:0] tries
);

    // The wait counter needs at least one bit even for a combinational checker.
    localparam int                c_wait_w    = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(CHK_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [VEC_W-1:0]    r_cand,   w_cand_nxt;
    logic [VEC_W-1:0]    r_sol,    w_sol_nxt;
    logic [CNT_W-1:0]    r_tries,  w_tries_nxt;
    logic [CNT_W-1:0]    r_max,    w_max_nxt;
    logic [c_wait_w-1:0] r_wait,   w_wait_nxt;
    logic                r_found,  w_found_nxt;

    logic [VEC_W-1:0]    w_seed_eff;
    logic [VEC_W-1:0]    w_cand_step;
    logic [CNT_W-1:0]    w_tries_inc;
    logic                w_sample;

`ifdef STIM_GEN_EXHAUSTIVE_EN
    // Plain enumeration: zero is a legitimate starting point.
    assign w_seed_eff  = seed;
    assign w_cand_step = r_cand + 1'b1;
`else
    // An all-zero state would lock the LFSR, so a zero seed becomes all-ones.
    assign w_seed_eff  = (seed == '0) ? '1 : seed;
    assign w_cand_step = r_cand[0] ? ((r_cand >> 1) ^ LFSR_TAPS) : (r_cand >> 1);
`endif

    assign w_tries_inc = r_tries + 1'b1;
    // The verdict is only trusted once the checker latency has elapsed.
    assign w_sample    = (r_wait == c_wait_last);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_sol   <= '0;
            r_tries <= '0;
            r_max   <= '0;
            r_wait  <= '0;
            r_found <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_sol   <= w_sol_nxt;
            r_tries <= w_tries_nxt;
            r_max   <= w_max_nxt;
            r_wait  <= w_wait_nxt;
            r_found <= w_found_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_sol_nxt   = r_sol;
        w_tries_nxt = r_tries;
        w_max_nxt   = r_max;
        w_wait_nxt  = r_wait;
        w_found_nxt = r_found;
        cand_valid  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_max_nxt   = max_tries;
                    w_found_nxt = 1'b0;
                    w_sol_nxt   = '0;
                    w_tries_nxt = '0;
                    w_wait_nxt  = '0;
                    w_cand_nxt  = w_seed_eff;
                    // A zero budget finishes without presenting anything.
                    w_state_nxt = (max_tries == '0) ? ST_FINISH : ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                cand_valid = 1'b1;
                busy       = 1'b1;
                if (w_sample) begin
                    w_tries_nxt = w_tries_inc;
                    if (chk_x) begin
                        w_sol_nxt   = r_cand;
                        w_found_nxt = 1'b1;
                        w_state_nxt = ST_FINISH;
                    end else if (w_tries_inc == r_max) begin
                        // Budget exhausted; tries stops at max_tries.
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_cand_nxt = w_cand_step;
                        w_wait_nxt = '0;
                    end
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end

            ST_FINISH: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cand  = r_cand;
    assign sol   = r_sol;
    assign tries = r_tries;
    assign found = r_found;

endmodule
`default_nettype wire

// File: tb/tb_split_stim_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_split_stim_gen
//  Purpose  : Self-checking bench for split_stim_gen. Two instances are used:
//             dut0 with a combinational checker (CHK_LAT=0) and dut2 with a
//             two-cycle checker latency (CHK_LAT=2). A trace model predicts
//             every cycle of each search from the candidate sequence and the
//             checker rule; directed literals pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_split_stim_gen;

    typedef struct {
        logic        cv;
        logic        busy;
        logic        done;
        logic [31:0] cand;
        logic        found;
        logic [31:0] sol;
        logic [15:0] tries;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0 (CHK_LAT = 0)
    logic        start0, cv0, busy0, done0, found0, chk0;
    logic [31:0] seed0, cand0, sol0;
    logic [15:0] max0, tries0;
    // dut2 (CHK_LAT = 2)
    logic        start2, cv2, busy2, done2, found2, chk2;
    logic [31:0] seed2, cand2, sol2;
    logic [15:0] max2, tries2;

    int          mode0 = 0, mode2 = 0;
    logic [31:0] tgt0 = '0;
    int          ph2 = 0;

    split_stim_gen #(.VEC_W(32), .CNT_W(16), .CHK_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0), .max_tries(max0),
        .cand(cand0), .cand_valid(cv0), .chk_x(chk0), .busy(busy0), .done(done0),
        .found(found0), .sol(sol0), .tries(tries0)
    );

    split_stim_gen #(.VEC_W(32), .CNT_W(16), .CHK_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .max_tries(max2),
        .cand(cand2), .cand_valid(cv2), .chk_x(chk2), .busy(busy2), .done(done2),
        .found(found2), .sol(sol2), .tries(tries2)
    );

    // Checkers: mode 1 = always true, mode 2 = true only for tgt0,
    // mode 3 (dut2) = true only in the second cycle of each 3-cycle hold.
    assign chk0 = (mode0 == 1) || ((mode0 == 2) && (cand0 == tgt0));
    always @(posedge clk) ph2 <= cv2 ? ph2 + 1 : 0;
    assign chk2 = (mode2 == 3) && cv2 && ((ph2 % 3) == 1);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    exp_t q0[$], q2[$];
    exp_t idle0, idle2;

    function automatic exp_t mk(input logic cv, input logic b, input logic d,
                                input logic [31:0] c, input logic f,
                                input logic [31:0] s, input logic [15:0] t);
        exp_t e;
        e.cv = cv; e.busy = b; e.done = d; e.cand = c;
        e.found = f; e.sol = s; e.tries = t;
        return e;
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] x);
`ifdef STIM_GEN_EXHAUSTIVE_EN
        return x + 32'd1;
`else
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
`endif
    endfunction

    // Verdict as seen at the sample point; the mode-3 pulse never lands there.
    function automatic logic model_sat(input int mode, input logic [31:0] tgt, input logic [31:0] c);
        return (mode == 1) || ((mode == 2) && (c == tgt));
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q2.push_back(e);
    endtask

    // Expected cycle-by-cycle trace from the cycle after the start edge.
    task automatic model_search(input int d, input int lat, input logic [31:0] s,
                                input logic [15:0] m, input int mode, input logic [31:0] tgt);
        logic [31:0] c;
        int          k;
        bit          fin;
        c = s;
`ifndef STIM_GEN_EXHAUSTIVE_EN
        if (c == 32'd0) c = 32'hFFFF_FFFF;
`endif
        if (m == 16'd0) begin
            push(d, mk(1'b0, 1'b0, 1'b1, c, 1'b0, 32'd0, 16'd0));
        end else begin
            k   = 0;
            fin = 1'b0;
            while (!fin) begin
                for (int h = 0; h <= lat; h++)
                    push(d, mk(1'b1, 1'b1, 1'b0, c, 1'b0, 32'd0, 16'(k)));
                if (model_sat(mode, tgt, c)) begin
                    push(d, mk(1'b0, 1'b0, 1'b1, c, 1'b1, c, 16'(k + 1)));
                    fin = 1'b1;
                end else if (k + 1 == int'(m)) begin
                    push(d, mk(1'b0, 1'b0, 1'b1, c, 1'b0, 32'd0, 16'(k + 1)));
                    fin = 1'b1;
                end else begin
                    c = model_next(c);
                    k++;
                end
            end
        end
    endtask

    // --------------------------------------------------------- compare
    task automatic cmp(input string tag, input exp_t e, input logic cv, input logic b,
                       input logic d, input logic [31:0] c, input logic f,
                       input logic [31:0] s, input logic [15:0] t);
        check({tag, ".cand_valid"}, cv, e.cv);
        check({tag, ".busy"},       b,  e.busy);
        check({tag, ".done"},       d,  e.done);
        check({tag, ".cand"},       c,  e.cand);
        check({tag, ".found"},      f,  e.found);
        check({tag, ".sol"},        s,  e.sol);
        check({tag, ".tries"},      t,  e.tries);
    endtask

    always @(negedge clk) begin : b_cmp
        exp_t e0, e2;
        if (rst_n) begin
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                idle0 = e0; idle0.cv = 1'b0; idle0.busy = 1'b0; idle0.done = 1'b0;
            end else begin
                e0 = idle0;
            end
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                idle2 = e2; idle2.cv = 1'b0; idle2.busy = 1'b0; idle2.done = 1'b0;
            end else begin
                e2 = idle2;
            end
            cmp("dut0", e0, cv0, busy0, done0, cand0, found0, sol0, tries0);
            cmp("dut2", e2, cv2, busy2, done2, cand2, found2, sol2, tries2);
        end
    end

    // Activity counters for the directed literals.
    int          cvcnt0 = 0, cvcnt2 = 0, donecnt0 = 0;
    logic [31:0] candlog0[$];
    always @(negedge clk) begin
        if (cv0) begin
            cvcnt0++;
            candlog0.push_back(cand0);
        end
        if (done0) donecnt0++;
        if (cv2) cvcnt2++;
    end

    task automatic clr_counts();
        cvcnt0 = 0; cvcnt2 = 0; donecnt0 = 0;
        candlog0.delete();
    endtask

    task automatic launch(input int d, input logic [31:0] s, input logic [15:0] m,
                          input int mode, input logic [31:0] tgt);
        @(negedge clk); #1;
        model_search(d, (d == 0) ? 0 : 2, s, m, mode, tgt);
        if (d == 0) begin
            mode0 = mode; tgt0 = tgt; seed0 = s; max0 = m; start0 = 1'b1;
        end else begin
            mode2 = mode; seed2 = s; max2 = m; start2 = 1'b1;
        end
        @(negedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 300; i++) begin
            if ((d == 0) ? done0 : done2) break;
            @(negedge clk); #1;
        end
        check("done_seen", (d == 0) ? done0 : done2, 1'b1);
    endtask

    // --------------------------------------------------------- stimulus
    initial begin
        logic [31:0] tgt;
        int          dups;
        start0 = 1'b0; seed0 = '0; max0 = '0;
        start2 = 1'b0; seed2 = '0; max2 = '0;
        idle0 = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 16'd0);
        idle2 = idle0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.cand", cand0, 32'd0);
        check("rst.cand_valid", cv0, 1'b0);
        check("rst.busy", busy0, 1'b0);
        check("rst.done", done0, 1'b0);
        check("rst.found", found0, 1'b0);
        check("rst.sol", sol0, 32'd0);
        check("rst.tries", tries0, 16'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Always-true checker
        clr_counts();
        launch(0, 32'h1, 16'd10, 1, 32'd0);
        wait_done(0);
        check("true.found", found0, 1'b1);
        check("true.sol", sol0, 32'h1);
        check("true.tries", tries0, 16'd1);
        repeat (3) @(negedge clk); #1;
        check("true.cv_cycles", 32'(cvcnt0), 32'd1);
        check("true.done_pulses", 32'(donecnt0), 32'd1);

        // Always-false checker, budget 5
        clr_counts();
        launch(0, 32'h1, 16'd5, 0, 32'd0);
        wait_done(0);
        check("false.found", found0, 1'b0);
        check("false.tries", tries0, 16'd5);
        @(negedge clk); #1;
        check("false.busy_after", busy0, 1'b0);
        check("false.cv_cycles", 32'(cvcnt0), 32'd5);
        check("false.first_cand", candlog0[0], 32'h1);
        dups = 0;
        for (int i = 0; i < candlog0.size(); i++)
            for (int j = i + 1; j < candlog0.size(); j++)
                if (candlog0[i] == candlog0[j]) dups++;
        check("false.distinct", 32'(dups), 32'd0);

        // Checker true only for the third candidate from seed 1
`ifdef STIM_GEN_EXHAUSTIVE_EN
        tgt = 32'h3;
`else
        tgt = 32'hC030_0002;
`endif
        launch(0, 32'h1, 16'd10, 2, tgt);
        wait_done(0);
        check("third.found", found0, 1'b1);
        check("third.tries", tries0, 16'd3);
        check("third.sol", sol0, tgt);

        // Zero seed
`ifdef STIM_GEN_EXHAUSTIVE_EN
        launch(0, 32'h0, 16'd20, 2, 32'h7);
        check("zero.first_cand", cand0, 32'h0);
        wait_done(0);
        check("zero.found", found0, 1'b1);
        check("zero.tries", tries0, 16'd8);
        check("zero.sol", sol0, 32'h7);
`else
        launch(0, 32'h0, 16'd2, 0, 32'd0);
        check("zero.first_cand", cand0, 32'hFFFF_FFFF);
        wait_done(0);
        check("zero.tries", tries0, 16'd2);
`endif

        // Zero budget
        clr_counts();
        launch(0, 32'h1234, 16'd0, 1, 32'd0);
        check("max0.done", done0, 1'b1);
        check("max0.tries", tries0, 16'd0);
        check("max0.found", found0, 1'b0);
        @(negedge clk); #1;
        check("max0.cv_cycles", 32'(cvcnt0), 32'd0);

        // Start while busy is ignored
        clr_counts();
        launch(0, 32'h5, 16'd6, 0, 32'd0);
        @(negedge clk); #1;
        start0 = 1'b1; seed0 = 32'h9; max0 = 16'd1;
        @(negedge clk); #1;
        start0 = 1'b0;
        wait_done(0);
        check("busy_start.tries", tries0, 16'd6);
        check("busy_start.cv_cycles", 32'(cvcnt0), 32'd6);
        check("busy_start.first_cand", candlog0[0], 32'h5);

        // CHK_LAT = 2 with a verdict pulse outside the sample cycle
        clr_counts();
        launch(2, 32'h1, 16'd4, 3, 32'd0);
        wait_done(2);
        check("lat2.found", found2, 1'b0);
        check("lat2.tries", tries2, 16'd4);
        check("lat2.cv_cycles", 32'(cvcnt2), 32'd12);

        // Asynchronous reset mid-search
        launch(0, 32'h1, 16'd20, 0, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete(); q2.delete();
        idle0 = mk(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 16'd0);
        idle2 = idle0;
        #1;
        check("arst.cand", cand0, 32'd0);
        check("arst.cand_valid", cv0, 1'b0);
        check("arst.busy", busy0, 1'b0);
        check("arst.tries", tries0, 16'd0);
        check("arst.sol", sol0, 32'd0);
        check("arst.dut2_tries", tries2, 16'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
